// File: rtl/shift_seq_ctrl_if.sv
// Bundle between host, shift_seq_ctrl and shifter8: request/response handshakes plus
// the shifter command lines and its registered readback.
interface shift_seq_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_data;
  logic [1:0] req_mode;
  logic [3:0] req_amt;
  logic [2:0] op;
  logic [1:0] shamt;
  logic [7:0] d_in;
  logic [7:0] shf_dout;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       busy;

  modport master (
    input  req_valid, req_data, req_mode, req_amt, shf_dout, rsp_ready,
    output req_ready, op, shamt, d_in, rsp_valid, rsp_data, busy
  );

  modport slave (
    output req_valid, req_data, req_mode, req_amt, shf_dout, rsp_ready,
    input  req_ready, op, shamt, d_in, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Sequencer for shifter8: loads a byte, splits the requested shift into steps the
// 2-bit shamt port can express, then hands the captured result back to the host.
module shift_seq_ctrl #(
  parameter int MAX_STEP = 3
) (
  input logic              clk,
  input logic              reset_n,
  shift_seq_ctrl_if.master bus
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_LSL  = 3'b010;
  localparam logic [2:0] OP_LSR  = 3'b011;
  localparam logic [2:0] OP_ASR  = 3'b100;
  localparam logic [3:0] STEP_LIMIT = 4'(MAX_STEP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_CAPT,
    S_RESP
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_data;
  logic [1:0] r_mode;
  logic [3:0] r_rem;
  logic [7:0] r_rsp_data;
  logic       r_rsp_valid;
  logic [3:0] w_step;
  logic [3:0] w_rem_after;
  logic [2:0] w_shift_op;

  assign w_step      = (r_rem > STEP_LIMIT) ? STEP_LIMIT : r_rem;
  assign w_rem_after = r_rem - w_step;

  always_comb begin
    case (r_mode)
      2'b00:   w_shift_op = OP_LSL;
      2'b01:   w_shift_op = OP_LSR;
      2'b10:   w_shift_op = OP_ASR;
      default: w_shift_op = OP_NOP;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Outputs depend only on state and latched registers, never on the handshake inputs.
  always_comb begin
    w_next        = r_state;
    bus.op        = OP_NOP;
    bus.shamt     = 2'd0;
    bus.req_ready = 1'b0;
    bus.busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        bus.busy      = 1'b0;
        if (bus.req_valid) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        bus.op = OP_LOAD;
        w_next = (r_rem != 4'd0) ? S_SHIFT : S_CAPT;
      end
      S_SHIFT: begin
        bus.op    = w_shift_op;
        bus.shamt = w_step[1:0];
        if (w_rem_after == 4'd0) begin
          w_next = S_CAPT;
        end
      end
      S_CAPT: begin
        w_next = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Load-only requests carry no remaining shift so LOAD falls straight through to CAPT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data      <= 8'h00;
      r_mode      <= 2'b00;
      r_rem       <= 4'd0;
      r_rsp_data  <= 8'h00;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_data <= bus.req_data;
            r_mode <= bus.req_mode;
            r_rem  <= (bus.req_mode == 2'b11) ? 4'd0 : bus.req_amt;
          end
        end
        S_SHIFT: begin
          r_rem <= w_rem_after;
        end
        S_CAPT: begin
          r_rsp_data  <= bus.shf_dout;
          r_rsp_valid <= 1'b1;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.d_in      = r_data;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_valid = r_rsp_valid;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: a behavioural shifter8 closes the loop, and a transaction
// model predicts every output cycle by cycle from the request alone.
module tb_shift_seq_ctrl;

  localparam int OP_NOP  = 0;
  localparam int OP_LOAD = 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [7:0] shfOut;

  int nCompared = 0;
  int nMismatched = 0;

  // Model state: 0 idle, 1 running the command trace, 2 response pending.
  int mPhase = 0;
  int expOp[$];
  int expShamt[$];
  logic [7:0] mDin = 8'h00;
  logic [7:0] mRspData = 8'h00;
  logic [7:0] mPending = 8'h00;

  shift_seq_ctrl_if bus ();

  shift_seq_ctrl #(.MAX_STEP(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Behavioural shifter8 with a registered output.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shfOut <= 8'h00;
    end else begin
      case (bus.op)
        3'd1: shfOut <= bus.d_in;
        3'd2: shfOut <= shfOut << bus.shamt;
        3'd3: shfOut <= shfOut >> bus.shamt;
        3'd4: shfOut <= 8'($signed(shfOut) >>> bus.shamt);
        default: shfOut <= shfOut;
      endcase
    end
  end

  assign bus.shf_dout = shfOut;

  function automatic logic [7:0] refResult(logic [7:0] data, logic [1:0] mode, logic [3:0] amt);
    logic [15:0] wide;
    case (mode)
      2'd0: begin
        wide = {8'h00, data} << amt;
        return wide[7:0];
      end
      2'd1: return data >> amt;
      2'd2: return 8'($signed(data) >>> amt);
      default: return data;
    endcase
  endfunction

  function automatic int refSteps(logic [1:0] mode, logic [3:0] amt);
    if (mode == 2'd3 || amt == 4'd0) return 0;
    return (int'(amt) + 2) / 3;
  endfunction

  function automatic int stepAmount(int idx, int n, logic [3:0] amt);
    return (idx < n - 1) ? 3 : int'(amt) - 3 * (n - 1);
  endfunction

  function automatic int packedSteps(logic [1:0] mode, logic [3:0] amt);
    int n = refSteps(mode, amt);
    int p = 0;
    for (int i = 0; i < n; i++) p = (p << 4) | stepAmount(i, n, amt);
    return p;
  endfunction

  task automatic checkOutput(string name, int got, int exp);
    nCompared++;
    if (got != exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction model: one command trace per accepted request, consumed one cycle per edge.
  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        mPhase = 0;
        expOp.delete();
        expShamt.delete();
        mDin = 8'h00;
        mRspData = 8'h00;
      end else begin
        case (mPhase)
          0: begin
            if (bus.req_valid) begin
              int n;
              n = refSteps(bus.req_mode, bus.req_amt);
              mDin = bus.req_data;
              mPending = refResult(bus.req_data, bus.req_mode, bus.req_amt);
              expOp.push_back(OP_LOAD);
              expShamt.push_back(0);
              for (int i = 0; i < n; i++) begin
                expOp.push_back(2 + int'(bus.req_mode));
                expShamt.push_back(stepAmount(i, n, bus.req_amt));
              end
              expOp.push_back(OP_NOP);
              expShamt.push_back(0);
              mPhase = 1;
            end
          end
          1: begin
            void'(expOp.pop_front());
            void'(expShamt.pop_front());
            if (expOp.size() == 0) begin
              mRspData = mPending;
              mPhase = 2;
            end
          end
          default: begin
            if (bus.rsp_ready) mPhase = 0;
          end
        endcase
      end
    end
  end

  // Compare every output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("op",        int'(bus.op),        (mPhase == 1) ? expOp[0] : OP_NOP);
      checkOutput("shamt",     int'(bus.shamt),     (mPhase == 1) ? expShamt[0] : 0);
      checkOutput("busy",      int'(bus.busy),      (mPhase != 0) ? 1 : 0);
      checkOutput("req_ready", int'(bus.req_ready), (mPhase == 0) ? 1 : 0);
      checkOutput("rsp_valid", int'(bus.rsp_valid), (mPhase == 2) ? 1 : 0);
      checkOutput("rsp_data",  int'(bus.rsp_data),  int'(mRspData));
      checkOutput("d_in",      int'(bus.d_in),      int'(mDin));
    end
  end

  task automatic applyStimulus(logic [7:0] data, logic [1:0] mode, logic [3:0] amt, int hold,
                               logic [7:0] expData, int expLat, int expSteps, bit noise);
    int lat = 0;
    int steps = 0;
    bit got = 0;
    @(posedge clk);
    #2;
    bus.req_data = data;
    bus.req_mode = mode;
    bus.req_amt = amt;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #2;
    bus.req_valid = 1'b0;
    bus.req_data = 8'($urandom);
    bus.req_amt = 4'($urandom);
    while (lat < 40 && !got) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.op >= 3'd2 && bus.op <= 3'd4) steps = (steps << 4) | int'(bus.shamt);
      if (bus.rsp_valid) got = 1;
      else if (noise) bus.rsp_ready = 1'($urandom);
    end
    bus.rsp_ready = 1'b0;
    checkOutput("latency", lat, expLat);
    checkOutput("step_trace", steps, expSteps);
    checkOutput("result", int'(bus.rsp_data), int'(expData));
    for (int i = 0; i < hold; i++) begin
      bus.req_valid = (noise && i == 2) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      checkOutput("hold_valid", int'(bus.rsp_valid), 1);
      checkOutput("hold_data", int'(bus.rsp_data), int'(expData));
      checkOutput("hold_req_ready", int'(bus.req_ready), 0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    checkOutput("req_ready_after_rsp", int'(bus.req_ready), 1);
    checkOutput("rsp_valid_after_rsp", int'(bus.rsp_valid), 0);
  endtask

  initial begin
    #200000;
    nMismatched++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_data = 8'h00;
    bus.req_mode = 2'b00;
    bus.req_amt = 4'd0;
    bus.rsp_ready = 1'b0;
    #13;
    checkOutput("reset_op", int'(bus.op), OP_NOP);
    checkOutput("reset_req_ready", int'(bus.req_ready), 1);
    checkOutput("reset_busy", int'(bus.busy), 0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;

    $display("[TB] directed requests");
    applyStimulus(8'h81, 2'd0, 4'd1,  0, 8'h02, 3, 32'h1,     1'b0);
    applyStimulus(8'h90, 2'd2, 4'd5,  0, 8'hFC, 4, 32'h32,    1'b0);
    applyStimulus(8'h80, 2'd2, 4'd15, 0, 8'hFF, 7, 32'h33333, 1'b0);
    applyStimulus(8'hF0, 2'd1, 4'd4,  5, 8'h0F, 4, 32'h31,    1'b1);
    applyStimulus(8'h5A, 2'd3, 4'd9,  0, 8'h5A, 2, 32'h0,     1'b0);

    $display("[TB] asynchronous reset during second shift step");
    @(posedge clk);
    #2;
    bus.req_data = 8'h33;
    bus.req_mode = 2'd0;
    bus.req_amt = 4'd9;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #2;
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    checkOutput("mid_shift_op", int'(bus.op), 2);
    checkOutput("mid_shift_shamt", int'(bus.shamt), 3);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("async_op", int'(bus.op), OP_NOP);
    checkOutput("async_shamt", int'(bus.shamt), 0);
    checkOutput("async_busy", int'(bus.busy), 0);
    checkOutput("async_req_ready", int'(bus.req_ready), 1);
    checkOutput("async_rsp_data", int'(bus.rsp_data), 0);
    checkOutput("async_d_in", int'(bus.d_in), 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    applyStimulus(8'h01, 2'd0, 4'd3, 0, 8'h08, 3, 32'h3, 1'b0);

    $display("[TB] randomized requests");
    for (int k = 0; k < 40; k++) begin
      logic [7:0] d;
      logic [1:0] m;
      logic [3:0] a;
      d = 8'($urandom);
      m = 2'($urandom_range(3, 0));
      a = 4'($urandom_range(15, 0));
      applyStimulus(d, m, a, int'($urandom_range(4, 0)), refResult(d, m, a),
                    refSteps(m, a) + 2, packedSteps(m, a), 1'b1);
    end

    repeat (3) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Command sequencer that drives the 8-bit shifter's control interface (op, shamt, d_in) and reads back its registered output (d_out).
- Accepts one shift request per valid/ready handshake: data, mode and a total shift amount of 0–15.
- Issues a LOAD, then splits the amount into steps of at most 3 (the shifter's shamt limit), then returns the result through a response handshake.
- Sits between a host/testbench and shifter8; it is the master end of the shifter command interface.

Parameters:
MAX_STEP, 3, largest shamt issued per shift cycle. Fixed by the 2-bit shamt port; not overridable in practice.

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request
req_data  input  8  value to load into the shifter
req_mode  input  2  shift mode: 00 LSL, 01 LSR, 10 ASR, 11 load-only
req_amt  input  4  total shift amount, 0–15
op  output  3  shifter opcode: NOP 000, LOAD 001, LSL 010, LSR 011, ASR 100
shamt  output  2  per-cycle shift amount to the shifter
d_in  output  8  load data to the shifter
shf_dout  input  8  shifter registered output (d_out)
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes the result
rsp_data  output  8  shifted result
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - op=NOP, shamt=0, d_in=0x00.
  - rsp_valid=0, rsp_data=0x00, busy=0, req_ready=1.
  - Internal remaining count and mode registers cleared.
- Reset mid-operation: abort immediately to the reset values. No response is produced for the aborted request.
- All outputs are registered or decoded from state only. There is no combinational path from req_* or rsp_ready to any output.
- FSM states: IDLE, LOAD, SHIFT, CAPT, RESP.
- IDLE:
  - req_ready=1, op=NOP.
  - On req_valid=1 at a rising edge: latch req_data, req_mode and rem=req_amt; go to LOAD.
  - Mode 11 forces rem=0.
- LOAD (1 cycle):
  - op=LOAD, d_in=latched data.
  - Next state: SHIFT if rem>0, else CAPT.
- SHIFT (one cycle per step):
  - op=LSL/LSR/ASR per the latched mode; shamt=min(rem,3).
  - At the clock edge: rem <= rem − shamt.
  - Leave for CAPT when the post-update rem=0.
  - Step count N = ceil(req_amt/3): amt 15 → 3,3,3,3,3; amt 7 → 3,3,1; amt 4 → 3,1.
- CAPT (1 cycle):
  - op=NOP. shf_dout now reflects the last shift.
  - At the edge: rsp_data <= shf_dout, rsp_valid <= 1; go to RESP.
- RESP:
  - op=NOP; rsp_valid and rsp_data held stable.
  - On rsp_ready=1 at an edge: rsp_valid <= 0; go to IDLE.
  - req_ready is 0, so no new request overlaps the response.
- Latency: for a request accepted at edge E0, rsp_valid rises after edge E0+N+2 (N=0 for amt 0 or mode 11). One request in flight at a time.
- Outside LOAD, d_in holds its last value. shamt=0 in every state except SHIFT.
- Amounts ≥8 are not clamped. The shifter naturally yields 0x00 (LSL/LSR) or sign-fill (ASR).
- req_valid while busy is ignored and not queued. rsp_ready while not in RESP is ignored.

Test Plan:
1. Reset, then req LSL data=0x81 amt=1.
   - Expected: op sequence LOAD, LSL(shamt=1), NOP.
   - Expected: rsp_valid 3 edges after accept, rsp_data=0x02.
2. ASR data=0x90 amt=5.
   - Expected: shamt sequence 3, then 2; rsp_data=0xFC.
   - Expected: ASR data=0x80 amt=15 gives five ASR cycles of shamt=3 and rsp_data=0xFF.
3. LSR data=0xF0 amt=4 → rsp_data=0x0F.
   - Expected: mode=11 data=0x5A amt=9 → LOAD only, zero SHIFT cycles, rsp_data=0x5A after E0+2.
4. Hold rsp_ready=0 for 5 cycles with rsp_data=0x0F pending.
   - Expected: rsp_valid and rsp_data stable throughout; req_ready=0; a req_valid pulse during this window is dropped.
   - Then assert rsp_ready → IDLE, req_ready=1.
5. Assert reset_n=0 asynchronously during the second SHIFT cycle of an amt=9 request.
   - Expected: outputs go to reset values immediately, without waiting for a clock edge.
   - After release, a new LSL 0x01 amt=3 returns 0x08 with no stale data.
